// File: rtl/ltc2308_scan.sv
// rtl/ltc2308_scan.sv - multi-channel scanning controller for the LTC2308 SPI ADC
//
// Walks channels 0..NCH-1 single-ended, driving CONVST/SCK/SDI and collecting
// SDO. The ADC applies the config word of frame k to the conversion of frame
// k+1, so a scan is NCH+1 frames: frame 0 is a dummy whose result is dropped,
// frame i (1..NCH) sends cfg(i mod NCH) and returns channel i-1.
// Frame length is CONV_CYCLES + 2*CLK_DIV*W + 1 clk cycles.
//
// Optional feature macro: LTC2308_SCAN_STORE_EN adds a per-channel result bank
// readable through rd_ch/rd_data (registered, 1-cycle latency, rd_ch>=NCH reads 0).
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   synchronous active-high reset
//   start      in   pulse, begins one scan when idle
//   cont       in   level, scans restart back-to-back while high
//   uni        in   UNI config bit, sampled at scan start
//   sdo        in   ADC serial data
//   convst     out  ADC conversion start
//   sck        out  ADC serial clock
//   sdi        out  ADC config input
//   busy       out  high from scan start to scan end
//   ch_data    out  last result (W bits)
//   ch_id      out  channel of ch_data
//   ch_valid   out  one-cycle pulse on new ch_data/ch_id
//   scan_done  out  one-cycle pulse with the last channel's ch_valid
//   rd_ch      in   (store build) bank read index
//   rd_data    out  (store build) registered bank[rd_ch]
module ltc2308_scan #(
  parameter int NCH         = 8,
  parameter int W           = 12,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont,
  input  logic         uni,
  input  logic         sdo,
  output logic         convst,
  output logic         sck,
  output logic         sdi,
  output logic         busy,
  output logic [W-1:0] ch_data,
  output logic [2:0]   ch_id,
  output logic         ch_valid,
  output logic         scan_done
`ifdef LTC2308_SCAN_STORE_EN
  ,
  input  logic [2:0]   rd_ch,
  output logic [W-1:0] rd_data
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  W_LAST    = 5'(W - 1);
  localparam logic [3:0]  LAST_FRM  = 4'(NCH);

  logic [1:0]   state;
  logic [15:0]  cnt;       // cycles within CONV, or within one SCK half-period
  logic [4:0]   bit_cnt;   // SCK periods completed in SHIFT
  logic [3:0]   frame;     // 0 = dummy frame, 1..NCH return channel frame-1
  logic         uni_l;
  logic [W-1:0] tx;        // remaining SDI bits after the one on the pin
  logic [W-1:0] rx;

  logic [2:0]   cfg_ch;
  logic [5:0]   cfg_word;
  logic         last_frame;
  logic [2:0]   res_ch;

  always_comb begin
    last_frame = (frame == LAST_FRM);
    // The final frame of a scan wraps back to channel 0 so the pipeline is primed.
    cfg_ch     = last_frame ? 3'd0 : frame[2:0];
    cfg_word   = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], uni_l, 1'b0};
    // frame==8 has frame[2:0]==0, so the 3-bit wrap still yields channel 7.
    res_ch     = frame[2:0] - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      uni_l     <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      convst    <= 1'b0;
      sck       <= 1'b0;
      sdi       <= 1'b0;
      busy      <= 1'b0;
      ch_data   <= '0;
      ch_id     <= '0;
      ch_valid  <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      ch_valid  <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          convst <= 1'b0;
          sck    <= 1'b0;
          busy   <= start | cont;
          if (start | cont) begin
            state  <= S_CONV;
            convst <= 1'b1;
            cnt    <= '0;
            frame  <= '0;
            uni_l  <= uni;
          end
        end
        S_CONV: begin
          if (cnt == CONV_LAST) begin
            state   <= S_SHIFT;
            convst  <= 1'b0;
            sdi     <= cfg_word[5];
            tx      <= {cfg_word[4:0], {(W-5){1'b0}}};
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
              rx  <= {rx[W-2:0], sdo};
            end else begin
              sck     <= 1'b0;
              sdi     <= tx[W-1];
              tx      <= {tx[W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == W_LAST) state <= S_GAP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin // S_GAP
          if (frame != 4'd0) begin
            ch_valid <= 1'b1;
            ch_data  <= rx;
            ch_id    <= res_ch;
          end
          cnt <= '0;
          if (last_frame) begin
            scan_done <= 1'b1;
            if (cont) begin
              // Back-to-back scan: skip IDLE so there is no gap between frames.
              state  <= S_CONV;
              convst <= 1'b1;
              frame  <= '0;
              uni_l  <= uni;
            end else begin
              // busy stays high through the scan_done cycle; IDLE clears it.
              state <= S_IDLE;
            end
          end else begin
            state  <= S_CONV;
            convst <= 1'b1;
            frame  <= frame + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef LTC2308_SCAN_STORE_EN
  logic [W-1:0] bank [NCH];
  logic         bank_we;

  always_comb begin
    bank_we = (state == S_GAP) && (frame != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bank_we && (res_ch == 3'(i))) bank[i] <= rx;
      end
      rd_data <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (rd_ch == 3'(i)) rd_data <= bank[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ltc2308_scan.sv
// tb/tb_ltc2308_scan.sv - self-checking bench for ltc2308_scan with an LTC2308 model
module tb_ltc2308_scan;
  localparam int NCH = 3, W = 12, CLK_DIV = 1, CONV_CYCLES = 4;
  localparam int F = CONV_CYCLES + 2 * CLK_DIV * W + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cont = 1'b0, uni = 1'b1, sdo = 1'b0;
  logic convst, sck, sdi, busy, ch_valid, scan_done;
  logic [W-1:0] ch_data;
  logic [2:0] ch_id;
`ifdef LTC2308_SCAN_STORE_EN
  logic [2:0] rd_ch = 3'd0;
  logic [W-1:0] rd_data;
`endif

  ltc2308_scan #(.NCH(NCH), .W(W), .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .uni(uni), .sdo(sdo),
    .convst(convst), .sck(sck), .sdi(sdi), .busy(busy), .ch_data(ch_data),
    .ch_id(ch_id), .ch_valid(ch_valid), .scan_done(scan_done)
`ifdef LTC2308_SCAN_STORE_EN
    , .rd_ch(rd_ch), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // ADC model: latches SDI on rising SCK, applies the previous frame's word to
  // the conversion started by CONVST, shifts the result out on falling SCK.
  logic [11:0] sdi_word = '0, out_sr = '0;
  int          sdi_bits = 0;
  logic [2:0]  conv_ch = '0;
  logic [11:0] sdi_q[$];

  always @(posedge sck) begin
    sdi_word = {sdi_word[10:0], sdi};
    sdi_bits++;
    if (sdi_bits == 12) sdi_q.push_back(sdi_word);
  end
  always @(posedge convst) begin
    if (sdi_bits == 12) conv_ch = {sdi_word[9], sdi_word[8], sdi_word[10]};
    sdi_bits = 0;
  end
  always @(negedge convst) begin
    out_sr = 12'hA00 + 12'(conv_ch);
    sdo    = out_sr[11];
    out_sr = out_sr << 1;
  end
  always @(negedge sck) begin
    sdo    = out_sr[11];
    out_sr = out_sr << 1;
  end

  // Scoreboard of expected results.
  typedef struct packed { logic [2:0] id; logic [11:0] data; logic last; } exp_t;
  exp_t sb[$];
  int n_valid = 0, n_done = 0, conv_rises = 0;

  task automatic push_scan();
    for (int c = 0; c < NCH; c++) sb.push_back({3'(c), 12'hA00 + 12'(c), (c == NCH - 1)});
  endtask

  always @(negedge clk) begin
    if (!rst && ch_valid) begin
      n_valid++;
      chk("sb_nonempty_at_valid", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ch_id", 32'(ch_id), 32'(e.id));
        chk("ch_data", 32'(ch_data), 32'(e.data));
        chk("scan_done_with_valid", 32'(scan_done), 32'(e.last));
      end
    end
    if (!rst && scan_done) begin
      n_done++;
      chk("scan_done_needs_valid", 32'(ch_valid), 1);
    end
  end

  // Waveform shape monitor: CONVST width, SCK count and SCK high time per frame.
  logic prev_convst = 1'b0, prev_sck = 1'b0, frame_ok = 1'b0;
  int   conv_len = 0, sck_rises = 0, sck_hi = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_convst = 1'b0; prev_sck = 1'b0; frame_ok = 1'b0;
      conv_len = 0; sck_rises = 0; sck_hi = 0;
    end else begin
      if (!prev_convst && convst) begin
        conv_rises++;
        chk("sck_low_at_conv_start", 32'(sck), 0);
        if (frame_ok) chk("sck_rises_per_frame", sck_rises, 12);
        frame_ok = 1'b0;
        conv_len = 0;
      end
      if (convst) conv_len++;
      if (prev_convst && !convst) begin
        chk("convst_high_len", conv_len, CONV_CYCLES);
        chk("sck_low_at_conv_end", 32'(sck), 0);
        sck_rises = 0;
        frame_ok  = 1'b1;
      end
      if (!prev_sck && sck) begin sck_rises++; sck_hi = 0; end
      if (sck) sck_hi++;
      if (prev_sck && !sck) chk("sck_high_len", sck_hi, CLK_DIV);
      prev_convst = convst;
      prev_sck    = sck;
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!ch_valid && k < 400);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 600) begin @(negedge clk); k++; end
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic check_words(input string tag, input logic [5:0] w0, input logic [5:0] w1,
                             input logic [5:0] w2, input logic [5:0] w3);
    logic [11:0] exp_w [4];
    exp_w[0] = {w0, 6'd0}; exp_w[1] = {w1, 6'd0}; exp_w[2] = {w2, 6'd0}; exp_w[3] = {w3, 6'd0};
    chk({tag, "_count"}, sdi_q.size(), 4);
    for (int i = 0; i < 4 && i < sdi_q.size(); i++) chk({tag, "_word"}, 32'(sdi_q[i]), 32'(exp_w[i]));
  endtask

  initial begin
    int k, v0, c0, dones;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_convst", 32'(convst), 0);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_sdi", 32'(sdi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ch_valid", 32'(ch_valid), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_ch_data", 32'(ch_data), 0);
    chk("rst_ch_id", 32'(ch_id), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single scan
    sdi_q.delete();
    start = 1'b1; uni = 1'b1; push_scan();
    @(negedge clk); start = 1'b0;
    chk("start_to_convst", 32'(convst), 1);
    chk("busy_at_start", 32'(busy), 1);
    wait_valid(k); chk("first_valid_latency", k, 2 * F);
    wait_valid(k); chk("valid_spacing_1", k, F);
    wait_valid(k); chk("valid_spacing_2", k, F);
    chk("busy_with_scan_done", 32'(busy), 1);
    @(negedge clk);
    chk("busy_after_scan", 32'(busy), 0);
    repeat (10) @(negedge clk);
    chk("ch_data_hold", 32'(ch_data), 32'h0A02);
    chk("ch_id_hold", 32'(ch_id), 2);
    check_words("single_sdi", 6'b100010, 6'b110010, 6'b100110, 6'b100010);

`ifdef LTC2308_SCAN_STORE_EN
    rd_ch = 3'd1; @(negedge clk); chk("rd_ch1", 32'(rd_data), 32'h0A01);
    rd_ch = 3'd0; @(negedge clk); chk("rd_ch0", 32'(rd_data), 32'h0A00);
    rd_ch = 3'd5; @(negedge clk); chk("rd_ch5", 32'(rd_data), 0);
`endif

    // start while busy and uni toggled mid-scan
    sdi_q.delete();
    start = 1'b1; uni = 1'b1; push_scan();
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1; uni = 1'b0;
    @(negedge clk); start = 1'b0;
    wait_idle();
    c0 = conv_rises;
    repeat (60) @(negedge clk);
    chk("no_extra_scan", conv_rises, c0);
    chk("still_idle", 32'(busy), 0);
    check_words("uni_hold_sdi", 6'b100010, 6'b110010, 6'b100110, 6'b100010);
    sdi_q.delete();
    start = 1'b1; push_scan();
    @(negedge clk); start = 1'b0;
    wait_idle();
    check_words("uni0_sdi", 6'b100000, 6'b110000, 6'b100100, 6'b100000);
    uni = 1'b1;
    repeat (5) @(negedge clk);

    // Continuous: two scans back-to-back
    v0 = n_valid; c0 = conv_rises; dones = 0;
    cont = 1'b1; push_scan(); push_scan();
    @(negedge clk);
    chk("cont_convst", 32'(convst), 1);
    k = 0;
    do begin
      @(negedge clk); k++;
      if (scan_done) begin dones++; cont = 1'b0; end
    end while (busy && k < 600);
    chk("cont_total_cycles", k, 8 * F + 1);
    chk("cont_scan_done", dones, 2);
    chk("cont_valid_count", n_valid - v0, 6);
    chk("cont_frames", conv_rises - c0, 8);
    repeat (5) @(negedge clk);

    // Reset mid-SHIFT of frame 2
    start = 1'b1; push_scan();
    @(negedge clk); start = 1'b0;
    wait_valid(k);
    repeat (CONV_CYCLES + 5) @(negedge clk);
    sb.delete();
    v0 = n_valid;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_sck", 32'(sck), 0);
    chk("rst_mid_convst", 32'(convst), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_valid_after_rst", n_valid - v0, 0);
    start = 1'b1; push_scan();
    @(negedge clk); start = 1'b0;
    wait_valid(k); chk("post_rst_first_latency", k, 2 * F);
    wait_idle();
    chk("post_rst_valids", n_valid - v0, 3);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
